ir_frame_sequencer: RTL and testbench
=====================================

// Module: ir_frame_sequencer
// PURPOSE
// Master sequencer for the IR array sensor read. Drives a byte-level I2C engine through one full frame
// read: START, address W, command, repeated START, address R, 18 data bytes, PEC byte, STOP.
// Checks the PEC, publishes PTAT plus 8 pixel words as one frame, and flags bus and PEC errors.
// Runs on a periodic timer or on a manual trigger. Sits between the I2C byte engine and the pixel consumers.
// PARAMETERS
// DEV_ADDR    7'h0A      sensor 7-bit I2C address
// CMD_BYTE    8'h4C      register/command byte written before the read
// PERIOD      1000000    clk cycles between automatic frame starts (>=2)
// AUTO        1          1 = timer-driven starts enabled; 0 = trigger only
// PORTS
// clk          in   1    system clock, all logic on posedge
// rst          in   1    asynchronous, active-low reset
// trigger      in   1    start one frame if idle; ignored while busy
// busy         out  1    high from first command issued until return to IDLE
// frame_valid  out  1    1-cycle pulse: ptat/pixels updated with a PEC-good frame
// ptat         out  16   sensor temperature word {byte1,byte0}
// pixels       out  128  pixel i at [16*i+:16] = {byte(2i+3), byte(2i+2)}
// pec_err      out  1    last frame PEC mismatch; held until next frame start
// nack_err     out  1    last frame saw slave NACK on a write; held until next frame start
// cmd_valid    out  1    command to I2C engine valid
// cmd_op       out  3    0 START, 1 STOP, 2 WRITE, 3 READ_ACK, 4 READ_NACK
// cmd_data     out  8    write byte (WRITE only, else 0)
// cmd_ready    in   1    engine accepts command
// rsp_valid    in   1    1-cycle pulse: command completed
// rsp_data     in   8    read byte (READ_* only)
// rsp_ack      in   1    WRITE only: 1 = slave ACKed
// BEHAVIOUR
// - Reset: busy, frame_valid, ptat, pixels, pec_err, nack_err, cmd_valid, cmd_op, cmd_data all 0. State IDLE.
//   Timer loads PERIOD-1. Reset mid-frame abandons the frame with no STOP issued; the engine is reset alongside.
// - Handshake: cmd_valid/cmd_op/cmd_data stay stable until the cycle cmd_valid&&cmd_ready (transfer).
//   cmd_valid drops the cycle after transfer. The next command is not raised until rsp_valid for the current one.
//   Exactly one command is outstanding at a time. Every op, including START and STOP, returns one rsp_valid.
// - Start condition in IDLE: trigger, or (AUTO && timer==0). Both at once give a single frame.
//   On start: timer reloads PERIOD-1; pec_err and nack_err clear; busy=1.
//   cmd_valid rises on the next cycle with op START.
// - Timer: decrements every cycle, saturating at 0, including while busy. If it expires during a frame,
//   the next frame starts on the first IDLE cycle.
// - States and commands, in order:
//   IDLE -> START1(START) -> ADDR_W(WRITE {DEV_ADDR,0}) -> CMD(WRITE CMD_BYTE) -> START2(START)
//   -> ADDR_R(WRITE {DEV_ADDR,1}) -> READ(READ_ACK x18, byte counter 0..17) -> PEC(READ_NACK)
//   -> STOP(STOP) -> DONE -> IDLE. 25 commands total.
// - NACK: rsp_ack==0 on any WRITE -> nack_err=1, go to STOP (issue STOP), then IDLE. No frame_valid.
// - Data capture: byte k is stored in a shadow buffer, little-endian. Bytes 0-1 -> PTAT; bytes 2..17 -> pixels 0..7.
// - PEC: CRC-8, poly 0x07, init 0x00, MSB first, over {DEV_ADDR,0}, CMD_BYTE, {DEV_ADDR,1}, data bytes 0..17.
//   Updated one byte per rsp_valid.
// - DONE (1 cycle):
//   - CRC == received PEC: copy shadow to ptat/pixels, frame_valid=1 for this cycle.
//   - CRC mismatch: pec_err=1; ptat/pixels keep their previous values.
//   busy drops on entry to IDLE.
// - rsp_valid with no command outstanding is ignored. trigger while busy is ignored, not queued.
// TESTING
// 1 trigger; slave model returns PTAT 0x01A0, pixels 0x0100..0x0107, correct PEC -> 25 commands in stated order,
//   one frame_valid pulse, ptat=0x01A0, pixels[15:0]=0x0100, pixels[127:112]=0x0107, pec_err=0.
// 2 same frame, PEC byte xor 0x01 -> no frame_valid, pec_err=1, ptat/pixels unchanged from test 1.
// 3 rsp_ack=0 on ADDR_W -> next command is STOP, no READ_* issued, nack_err=1, busy=0 after STOP response.
// 4 cmd_ready held low 5 cycles on CMD -> cmd_valid/op=2/data=0x4C stable throughout; one transfer only.
// 5 AUTO=1, PERIOD=200, zero-latency engine -> frames start exactly 200 cycles apart; trigger pulse mid-frame ignored.
// 6 rst low during READ byte 7 -> all outputs 0 next cycle; after release + trigger, first command is START.

Source files
------------

// File: rtl/ir_frame_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ir_frame_sequencer: drives an I2C byte engine through one IR-sensor frame read (rev 1.0)
// -----------------------------------------------------------------------------
module ir_frame_sequencer #(
  parameter logic [6:0]  DEV_ADDR = 7'h0A,
  parameter logic [7:0]  CMD_BYTE = 8'h4C,
  parameter int unsigned PERIOD   = 1000000,
  parameter bit          AUTO     = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         trigger_i,
  output logic         busy_o,
  output logic         frame_valid_o,
  output logic [15:0]  ptat_o,
  output logic [127:0] pixels_o,
  output logic         pec_err_o,
  output logic         nack_err_o,
  output logic         cmd_valid_o,
  output logic [2:0]   cmd_op_o,
  output logic [7:0]   cmd_data_o,
  input  logic         cmd_ready_i,
  input  logic         rsp_valid_i,
  input  logic [7:0]   rsp_data_i,
  input  logic         rsp_ack_i
);

  localparam int TW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(PERIOD - 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_START1 = 4'd1;
  localparam logic [3:0] S_ADDR_W = 4'd2;
  localparam logic [3:0] S_CMD    = 4'd3;
  localparam logic [3:0] S_START2 = 4'd4;
  localparam logic [3:0] S_ADDR_R = 4'd5;
  localparam logic [3:0] S_READ   = 4'd6;
  localparam logic [3:0] S_PEC    = 4'd7;
  localparam logic [3:0] S_STOP   = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;

  localparam logic [2:0] OP_START  = 3'd0;
  localparam logic [2:0] OP_STOP   = 3'd1;
  localparam logic [2:0] OP_WRITE  = 3'd2;
  localparam logic [2:0] OP_RDACK  = 3'd3;
  localparam logic [2:0] OP_RDNACK = 3'd4;

  logic [3:0]    state_q, state_d;
  logic          sent_q, sent_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [7:0]    crc_q, crc_d;
  logic          pec_ok_q, pec_ok_d;
  logic [143:0]  shadow_q, shadow_d;
  logic [15:0]   ptat_q, ptat_d;
  logic [127:0]  pixels_q, pixels_d;
  logic          frame_valid_q, frame_valid_d;
  logic          pec_err_q, pec_err_d;
  logic          nack_err_q, nack_err_d;

  logic       w_start;
  logic       w_xfer;
  logic       w_rsp;
  logic [7:0] w_wr_byte;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] x;
    x = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h07) : {x[6:0], 1'b0};
    end
    return x;
  endfunction

  assign w_start   = (state_q == S_IDLE) && (trigger_i || (AUTO && (timer_q == '0)));
  assign w_xfer    = cmd_valid_o && cmd_ready_i;
  // Responses only count while a transferred command is awaiting completion.
  assign w_rsp     = rsp_valid_i && sent_q;
  assign w_wr_byte = (state_q == S_ADDR_W) ? {DEV_ADDR, 1'b0} :
                     (state_q == S_ADDR_R) ? {DEV_ADDR, 1'b1} : CMD_BYTE;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      sent_q        <= 1'b0;
      timer_q       <= TIMER_RELOAD;
      cnt_q         <= '0;
      crc_q         <= '0;
      pec_ok_q      <= 1'b0;
      shadow_q      <= '0;
      ptat_q        <= '0;
      pixels_q      <= '0;
      frame_valid_q <= 1'b0;
      pec_err_q     <= 1'b0;
      nack_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sent_q        <= sent_d;
      timer_q       <= timer_d;
      cnt_q         <= cnt_d;
      crc_q         <= crc_d;
      pec_ok_q      <= pec_ok_d;
      shadow_q      <= shadow_d;
      ptat_q        <= ptat_d;
      pixels_q      <= pixels_d;
      frame_valid_q <= frame_valid_d;
      pec_err_q     <= pec_err_d;
      nack_err_q    <= nack_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sent_d        = sent_q;
    cnt_d         = cnt_q;
    crc_d         = crc_q;
    pec_ok_d      = pec_ok_q;
    shadow_d      = shadow_q;
    ptat_d        = ptat_q;
    pixels_d      = pixels_q;
    frame_valid_d = 1'b0;
    pec_err_d     = pec_err_q;
    nack_err_d    = nack_err_q;

    if (w_start)               timer_d = TIMER_RELOAD;
    else if (timer_q == '0)    timer_d = '0;
    else                       timer_d = timer_q - 1'b1;

    if (w_xfer) sent_d = 1'b1;
    if (w_rsp)  sent_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          state_d    = S_START1;
          sent_d     = 1'b0;
          cnt_d      = '0;
          crc_d      = '0;
          pec_err_d  = 1'b0;
          nack_err_d = 1'b0;
        end
      end
      S_START1: if (w_rsp) state_d = S_ADDR_W;
      S_START2: if (w_rsp) state_d = S_ADDR_R;
      S_ADDR_W, S_CMD, S_ADDR_R: begin
        if (w_rsp) begin
          crc_d = crc8_byte(crc_q, w_wr_byte);
          if (!rsp_ack_i) begin
            nack_err_d = 1'b1;
            state_d    = S_STOP;
          end else if (state_q == S_ADDR_W) begin
            state_d = S_CMD;
          end else if (state_q == S_CMD) begin
            state_d = S_START2;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (w_rsp) begin
          shadow_d[{cnt_q, 3'b000} +: 8] = rsp_data_i;
          crc_d = crc8_byte(crc_q, rsp_data_i);
          if (cnt_q == 5'd17) state_d = S_PEC;
          else                cnt_d   = cnt_q + 5'd1;
        end
      end
      S_PEC: begin
        if (w_rsp) begin
          pec_ok_d = (rsp_data_i == crc_q);
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        // Publishing on the STOP response makes frame_valid coincide with DONE.
        if (w_rsp) begin
          if (nack_err_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            if (pec_ok_q) begin
              ptat_d        = shadow_q[15:0];
              pixels_d      = shadow_q[143:16];
              frame_valid_d = 1'b1;
            end else begin
              pec_err_d = 1'b1;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid_o = 1'b0;
    cmd_op_o    = OP_START;
    cmd_data_o  = 8'h00;
    case (state_q)
      S_START1, S_START2: begin
        cmd_valid_o = !sent_q;
        cmd_op_o    = OP_START;
      end
      S_ADDR_W, S_CMD, S_ADDR_R: begin
        cmd_valid_o = !sent_q;
        cmd_op_o    = OP_WRITE;
        cmd_data_o  = w_wr_byte;
      end
      S_READ: begin
        cmd_valid_o = !sent_q;
        cmd_op_o    = OP_RDACK;
      end
      S_PEC: begin
        cmd_valid_o = !sent_q;
        cmd_op_o    = OP_RDNACK;
      end
      S_STOP: begin
        cmd_valid_o = !sent_q;
        cmd_op_o    = OP_STOP;
      end
      default: ;
    endcase
    if (!cmd_valid_o) begin
      cmd_op_o   = OP_START;
      cmd_data_o = 8'h00;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign frame_valid_o = frame_valid_q;
  assign ptat_o        = ptat_q;
  assign pixels_o      = pixels_q;
  assign pec_err_o     = pec_err_q;
  assign nack_err_o    = nack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_frame_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_ir_frame_sequencer: directed bench with a cycle-level I2C engine/slave model (rev 1.0)
// -----------------------------------------------------------------------------
module tb_ir_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst_n, trigger, busy, fv, pec_err, nack_err, cmd_valid, cmd_ready, rsp_valid, rsp_ack;
  logic [15:0]  ptat;
  logic [127:0] pixels;
  logic [2:0]   cmd_op;
  logic [7:0]   cmd_data, rsp_data;

  logic         rst_a, trigger_a, busy_a, fv_a, pec_err_a, nack_err_a, cmd_valid_a, cmd_ready_a, rsp_valid_a, rsp_ack_a;
  logic [15:0]  ptat_a;
  logic [127:0] pixels_a;
  logic [2:0]   cmd_op_a;
  logic [7:0]   cmd_data_a, rsp_data_a;

  ir_frame_sequencer #(.DEV_ADDR(7'h0A), .CMD_BYTE(8'h4C), .PERIOD(1000), .AUTO(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .trigger_i(trigger), .busy_o(busy), .frame_valid_o(fv),
    .ptat_o(ptat), .pixels_o(pixels), .pec_err_o(pec_err), .nack_err_o(nack_err),
    .cmd_valid_o(cmd_valid), .cmd_op_o(cmd_op), .cmd_data_o(cmd_data), .cmd_ready_i(cmd_ready),
    .rsp_valid_i(rsp_valid), .rsp_data_i(rsp_data), .rsp_ack_i(rsp_ack));

  ir_frame_sequencer #(.DEV_ADDR(7'h0A), .CMD_BYTE(8'h4C), .PERIOD(200), .AUTO(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_a), .trigger_i(trigger_a), .busy_o(busy_a), .frame_valid_o(fv_a),
    .ptat_o(ptat_a), .pixels_o(pixels_a), .pec_err_o(pec_err_a), .nack_err_o(nack_err_a),
    .cmd_valid_o(cmd_valid_a), .cmd_op_o(cmd_op_a), .cmd_data_o(cmd_data_a), .cmd_ready_i(cmd_ready_a),
    .rsp_valid_i(rsp_valid_a), .rsp_data_i(rsp_data_a), .rsp_ack_i(rsp_ack_a));

  // Zero-latency engine: always ready, completes each command on the following cycle.
  logic a_pend = 1'b0;
  always @(negedge clk) begin
    rsp_valid_a = a_pend;
    a_pend      = cmd_valid_a && cmd_ready_a;
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0]   rd_bytes [18];
  logic [7:0]   pec_byte;
  int           nack_idx    = -1;
  int           stall_idx   = -1;
  int           stall_n     = 0;
  int           abort_after = -1;
  logic [2:0]   log_op [$];
  logic [7:0]   log_data [$];
  int           fv_cnt;
  logic         busy_after_stop, fv_after_stop;
  logic [127:0] exp_pix1;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = c ^ b;
    for (int i = 0; i < 8; i++) x = x[7] ? ({x[6:0], 1'b0} ^ 8'h07) : {x[6:0], 1'b0};
    return x;
  endfunction

  task automatic set_frame(input logic [15:0] pt, input logic [15:0] pixbase, input bit bad_pec);
    logic [15:0] w;
    logic [7:0]  c;
    rd_bytes[0] = pt[7:0];
    rd_bytes[1] = pt[15:8];
    for (int i = 0; i < 8; i++) begin
      w = pixbase + 16'(i);
      rd_bytes[2*i+2] = w[7:0];
      rd_bytes[2*i+3] = w[15:8];
    end
    c = crc8(8'h00, 8'h14);
    c = crc8(c, 8'h4C);
    c = crc8(c, 8'h15);
    for (int k = 0; k < 18; k++) c = crc8(c, rd_bytes[k]);
    pec_byte = bad_pec ? (c ^ 8'h01) : c;
  endtask

  task automatic pulse_trigger();
    log_op.delete();
    log_data.delete();
    fv_cnt = 0;
    busy_after_stop = 1'bx;
    fv_after_stop   = 1'bx;
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
  endtask

  task automatic serve(input int max_cyc);
    bit pend = 0, done = 0, stop_pend = 0, stop_done = 0;
    logic [2:0] p_op = 3'd0;
    int p_idx = 0, rd = 0, c = 0;
    while (!done && c < max_cyc) begin
      @(negedge clk);
      c++;
      if (fv) fv_cnt++;
      if (stop_pend) begin
        busy_after_stop = busy;
        fv_after_stop   = fv;
        stop_pend = 0;
        stop_done = 1;
      end
      rsp_valid = 1'b0; rsp_data = 8'h00; rsp_ack = 1'b0; cmd_ready = 1'b0;
      if (stop_done && !busy) begin
        done = 1;
      end else if (pend) begin
        pend = 0;
        rsp_valid = 1'b1;
        case (p_op)
          3'd1: stop_pend = 1;
          3'd2: rsp_ack = (p_idx != nack_idx);
          3'd3: begin if (rd < 18) rsp_data = rd_bytes[rd]; rd++; end
          3'd4: rsp_data = pec_byte;
          default: ;
        endcase
      end else if (cmd_valid) begin
        if (log_op.size() == stall_idx && stall_n > 0) begin
          stall_n--;
          check("stall_hold", {cmd_valid, cmd_op, cmd_data}, {1'b1, 3'd2, 8'h4C});
        end else begin
          cmd_ready = 1'b1;
          p_op  = cmd_op;
          p_idx = log_op.size();
          log_op.push_back(cmd_op);
          log_data.push_back(cmd_data);
          pend = 1;
          if (log_op.size() == abort_after) done = 1;
        end
      end
    end
    check("serve_done", done, 1'b1);
  endtask

  task automatic wait_rise(output int t, output bit ok);
    logic prev;
    ok = 0; t = 0;
    prev = busy_a;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (!prev && busy_a) begin t = cyc; ok = 1; end
      prev = busy_a;
    end
  endtask

  initial begin
    logic [2:0] exp_op [25];
    logic [7:0] exp_dat [25];
    int n_rd, n_cmd, t0, t1, t2;
    bit ok0, ok1, ok2;

    rst_n = 1'b0; rst_a = 1'b0; trigger = 1'b0; trigger_a = 1'b0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 8'h00; rsp_ack = 1'b0;
    cmd_ready_a = 1'b1; rsp_data_a = 8'h00; rsp_ack_a = 1'b1;
    for (int i = 0; i < 8; i++) exp_pix1[16*i +: 16] = 16'h0100 + 16'(i);

    exp_op[0] = 3'd0; exp_dat[0] = 8'h00;
    exp_op[1] = 3'd2; exp_dat[1] = 8'h14;
    exp_op[2] = 3'd2; exp_dat[2] = 8'h4C;
    exp_op[3] = 3'd0; exp_dat[3] = 8'h00;
    exp_op[4] = 3'd2; exp_dat[4] = 8'h15;
    for (int i = 5; i < 23; i++) begin exp_op[i] = 3'd3; exp_dat[i] = 8'h00; end
    exp_op[23] = 3'd4; exp_dat[23] = 8'h00;
    exp_op[24] = 3'd1; exp_dat[24] = 8'h00;

    repeat (3) @(negedge clk);
    rst_n = 1'b1; rst_a = 1'b1;
    @(negedge clk);
    check("rst_flags", {busy, fv, pec_err, nack_err, cmd_valid, cmd_op, cmd_data}, '0);
    check("rst_data", {ptat, pixels}, '0);

    // Test 1: good frame
    set_frame(16'h01A0, 16'h0100, 1'b0);
    pulse_trigger();
    serve(200);
    check("t1_len", log_op.size(), 25);
    for (int i = 0; i < 25 && i < log_op.size(); i++)
      check($sformatf("t1_cmd%0d", i), {log_op[i], log_data[i]}, {exp_op[i], exp_dat[i]});
    check("t1_fv_cnt", fv_cnt, 1);
    check("t1_fv_done", {fv_after_stop, busy_after_stop}, 2'b11);
    check("t1_ptat", ptat, 16'h01A0);
    check("t1_pix0", pixels[15:0], 16'h0100);
    check("t1_pix7", pixels[127:112], 16'h0107);
    check("t1_pixels", pixels, exp_pix1);
    check("t1_errs", {pec_err, nack_err, busy}, 3'b000);

    // Test 2: bad PEC on a different payload must leave outputs untouched
    set_frame(16'h0BEE, 16'h0200, 1'b1);
    pulse_trigger();
    serve(200);
    check("t2_len", log_op.size(), 25);
    check("t2_fv_cnt", fv_cnt, 0);
    check("t2_pec_err", pec_err, 1'b1);
    check("t2_ptat", ptat, 16'h01A0);
    check("t2_pixels", pixels, exp_pix1);

    // Test 3: NACK on the address-write
    set_frame(16'h01A0, 16'h0100, 1'b0);
    nack_idx = 1;
    pulse_trigger();
    serve(200);
    nack_idx = -1;
    n_rd = 0;
    foreach (log_op[i]) if (log_op[i] == 3'd3 || log_op[i] == 3'd4) n_rd++;
    check("t3_len", log_op.size(), 3);
    if (log_op.size() >= 3) check("t3_stop", {log_op[2], log_data[2]}, {3'd1, 8'h00});
    check("t3_no_read", n_rd, 0);
    check("t3_errs", {nack_err, pec_err}, 2'b10);
    check("t3_busy_after_stop", busy_after_stop, 1'b0);
    check("t3_fv_cnt", fv_cnt, 0);

    // Test 4: engine stalls the command byte for 5 cycles
    stall_idx = 2; stall_n = 5;
    pulse_trigger();
    serve(200);
    stall_idx = -1;
    n_cmd = 0;
    foreach (log_op[i]) if (log_op[i] == 3'd2 && log_data[i] == 8'h4C) n_cmd++;
    check("t4_stall_cycles", stall_n, 0);
    check("t4_len", log_op.size(), 25);
    check("t4_one_cmd", n_cmd, 1);
    check("t4_fv_cnt", fv_cnt, 1);
    check("t4_nack_clr", nack_err, 1'b0);

    // Test 6: reset while read byte 7 is in flight
    abort_after = 13;
    pulse_trigger();
    serve(200);
    abort_after = -1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 8'h00; rsp_ack = 1'b0;
    @(negedge clk);
    check("t6_rst_flags", {busy, fv, pec_err, nack_err, cmd_valid, cmd_op, cmd_data}, '0);
    check("t6_rst_data", {ptat, pixels}, '0);
    @(negedge clk) rst_n = 1'b1;
    pulse_trigger();
    serve(200);
    check("t6_len", log_op.size(), 25);
    if (log_op.size() > 0) check("t6_first", {log_op[0], log_data[0]}, {3'd0, 8'h00});
    check("t6_fv_cnt", fv_cnt, 1);
    check("t6_ptat", ptat, 16'h01A0);

    // Test 5: timer-driven starts on the AUTO instance
    wait_rise(t0, ok0);
    repeat (10) @(negedge clk);
    trigger_a = 1'b1;
    check("t5_trig_busy", busy_a, 1'b1);
    @(negedge clk) trigger_a = 1'b0;
    wait_rise(t1, ok1);
    wait_rise(t2, ok2);
    check("t5_seen", {ok0, ok1, ok2}, 3'b111);
    check("t5_gap1", t1 - t0, 200);
    check("t5_gap2", t2 - t1, 200);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
